btb_2way: RTL and testbench
===========================

BTB_2WAY -- requirements
Module: btb_2way

Interface
REQ-001 The module SHALL have parameter NUM_SETS, default 256, meaning the number of sets; it SHALL be a power of two, from 4 to 1024.
REQ-002 The module SHALL have parameter PC_W, default 32, meaning the PC and target width in bits.
REQ-003 The module SHALL have port i_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The module SHALL have port i_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The module SHALL have port i_lkp_valid, input, 1 bit: lookup request.
REQ-006 The module SHALL have port i_lkp_pc, input, PC_W bits: fetch PC to look up.
REQ-007 The module SHALL have port o_lkp_valid, input-registered output, 1 bit: lookup result valid.
REQ-008 The module SHALL have port o_lkp_hit, output, 1 bit: tag match on a valid entry.
REQ-009 The module SHALL have port o_lkp_taken, output, 1 bit: predict taken.
REQ-010 The module SHALL have port o_lkp_target, output, PC_W bits: predicted target.
REQ-011 The module SHALL have port i_upd_valid, input, 1 bit: resolved-branch update.
REQ-012 The module SHALL have ports i_upd_pc and i_upd_target, inputs, PC_W bits each: branch PC and resolved target.
REQ-013 The module SHALL have port i_upd_taken, input, 1 bit: resolved direction.
REQ-014 The module SHALL have port i_flush, input, 1 bit: invalidate all entries.
REQ-015 The module SHALL have port o_ready, output, 1 bit: high when not flushing.

Function
REQ-016 Addressing SHALL be: index = pc[IDX_W+1:2], where IDX_W = log2(NUM_SETS); tag = pc[PC_W-1:IDX_W+2].
REQ-017 Each set SHALL hold 2 ways; each way SHALL hold valid, tag, target and a 2-bit counter. Each set SHALL hold one LRU bit naming the victim way.
REQ-018 Lookup latency SHALL be 1 cycle: o_lkp_* SHALL reflect the i_lkp_pc sampled on the previous edge, and o_lkp_valid SHALL equal i_lkp_valid delayed by one cycle.
REQ-019 Hit SHALL mean any way is valid and its tag matches. If both ways match, way0 SHALL win.
REQ-020 o_lkp_taken SHALL equal hit AND counter[1]. o_lkp_target SHALL be the hit way's target, or 0 on a miss.
REQ-021 An update that hits SHALL rewrite that way's target and saturate its counter: taken increments, capped at 3; not-taken decrements, floored at 0.
REQ-022 An update that misses with taken=1 SHALL allocate the first invalid way (way0 first), otherwise the LRU way. It SHALL write tag, target and counter=2'b10.
REQ-023 An update that misses with taken=0 SHALL write nothing.
REQ-024 The LRU bit SHALL be set to the way not touched on an update hit or allocation. Lookup hits SHALL also set LRU away from the hit way. If both events hit the same set in one cycle, the update SHALL win.
REQ-025 Update and lookup to the same set in the same cycle SHALL be read-before-write: the lookup returns the old contents.
REQ-026 The FSM SHALL have states IDLE and FLUSH. i_flush in IDLE SHALL move to FLUSH. FLUSH SHALL clear valid and LRU of set flush_cnt each cycle, for cnt = 0..NUM_SETS-1, then return to IDLE.
REQ-027 In FLUSH, o_ready SHALL be 0, lookups SHALL return hit=0 and taken=0 (o_lkp_valid still tracks the request), and updates SHALL be dropped.
REQ-028 i_flush asserted while in FLUSH SHALL restart flush_cnt at 0.

Reset
REQ-029 On i_rst_n=0 at an edge: state=FLUSH, flush_cnt=0, o_lkp_valid=0, o_lkp_hit=0, o_lkp_taken=0, o_lkp_target=0, o_ready=0.
REQ-030 After release, o_ready SHALL rise exactly NUM_SETS cycles later.
REQ-031 Reset asserted mid-flush or mid-operation SHALL restart the flush from set 0.

Configuration
REQ-032 Macro BTB_COUNTER_EN defined: 2-bit counters SHALL be stored and used as in REQ-020 and REQ-021.
REQ-033 Macro BTB_COUNTER_EN undefined: no counter storage. o_lkp_taken SHALL equal hit. A not-taken update that hits SHALL invalidate that way.

Structure
REQ-034 Package btb_pkg SHALL hold the btb_state_e enum (IDLE, FLUSH), the way-entry struct, the counter constants CNT_INIT=2'b10 and CNT_MAX=2'b11, and the IDX_W/tag-width functions.
REQ-035 One sub-module, btb_way_ram, SHALL be instantiated once per way. It SHALL have a synchronous write port and a registered read port on the rising edge. Valid and LRU bits SHALL live in flops in btb_2way.

Verification
REQ-036 Reset, NUM_SETS=256 -> o_ready=0 for 256 cycles, then 1; any lookup in that window returns hit=0.
REQ-037 Update pc=0x0000_1000, target=0x2000, taken=1; next-cycle lookup 0x1000 -> hit=1, taken=1, target=0x2000.
REQ-038 Two not-taken updates to 0x1000 -> counter 2->1->0, lookup taken=0, hit=1. Without BTB_COUNTER_EN, the first not-taken update gives hit=0.
REQ-039 Three taken updates mapping to set 0 (0x0, 0x400, 0x800) -> the third evicts the LRU entry 0x0; lookup 0x0 misses, 0x400 and 0x800 hit.
REQ-040 Same-cycle update and lookup to a new pc -> lookup misses; a lookup one cycle later hits.
REQ-041 i_flush after filling entries, re-asserted at cnt=100 -> o_ready low 100+NUM_SETS cycles, then all lookups miss.

Source files
------------

// File: rtl/btb_pkg.sv
// btb_pkg: shared state type, per-way status struct, counter constants and geometry helpers.
// Feature macro BTB_COUNTER_EN adds a 2-bit direction counter to every way.
package btb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } btb_state_e;

    localparam logic [1:0] CNT_INIT = 2'b10;
    localparam logic [1:0] CNT_MAX  = 2'b11;

    // Per-way status bits; tag and target widths follow module parameters and live beside it.
    typedef struct packed {
        logic       valid;
`ifdef BTB_COUNTER_EN
        logic [1:0] cnt;
`endif
    } btb_way_t;

    function automatic int idx_w(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int tag_w(input int pc_w, input int num_sets);
        return pc_w - $clog2(num_sets) - 2;
    endfunction

    function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == CNT_MAX) ? cnt : cnt + 2'b01;
        end
        return (cnt == 2'b00) ? cnt : cnt - 2'b01;
    endfunction

endpackage

// File: rtl/btb_way_ram.sv
// btb_way_ram: target storage for one BTB way; synchronous write, registered read-first port.
module btb_way_ram #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: memory arrays get no reset; the owner's valid bits decide whether a word is meaningful.
    always_ff @(posedge i_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/btb_2way.sv
// btb_2way: 2-way set-associative BTB with 1-cycle lookup, single-cycle update and a set-by-set flush.
// Feature macro BTB_COUNTER_EN enables per-way 2-bit direction counters.
module btb_2way
    import btb_pkg::*;
#(
    parameter int NUM_SETS = 256,
    parameter int PC_W     = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_lkp_valid,
    input  logic [PC_W-1:0] i_lkp_pc,
    output logic            o_lkp_valid,
    output logic            o_lkp_hit,
    output logic            o_lkp_taken,
    output logic [PC_W-1:0] o_lkp_target,
    input  logic            i_upd_valid,
    input  logic [PC_W-1:0] i_upd_pc,
    input  logic [PC_W-1:0] i_upd_target,
    input  logic            i_upd_taken,
    input  logic            i_flush,
    output logic            o_ready
);

    localparam int IDX_W = idx_w(NUM_SETS);
    localparam int TAG_W = tag_w(PC_W, NUM_SETS);

    btb_state_e          state_q;
    logic [IDX_W-1:0]    flush_cnt_q;
    logic [IDX_W-1:0]    flush_set;

    btb_way_t            meta_q [2][NUM_SETS];
    logic [TAG_W-1:0]    tag_q  [2][NUM_SETS];
    logic [NUM_SETS-1:0] lru_q;

    logic [IDX_W-1:0]    lkp_idx;
    logic [IDX_W-1:0]    upd_idx;
    logic [TAG_W-1:0]    lkp_tag;
    logic [TAG_W-1:0]    upd_tag;
    logic                active;
    logic [1:0]          lkp_match;
    logic [1:0]          upd_match;
    logic                lkp_hit;
    logic                lkp_way;
    logic                lkp_taken;
    logic                upd_hit;
    logic                alloc_way;
    logic                upd_way;

    logic [1:0]          ram_we;
    logic [1:0]          tag_we;
    logic [1:0]          meta_we;
    btb_way_t            meta_wdata;
    logic                lru_we;
    logic [PC_W-1:0]     ram_rdata [2];

    logic                lkp_valid_q;
    logic                lkp_hit_q;
    logic                lkp_taken_q;
    logic                lkp_way_q;

    logic                unused_pc_lsb;

    assign lkp_idx = i_lkp_pc[IDX_W+1:2];
    assign lkp_tag = i_lkp_pc[PC_W-1:IDX_W+2];
    assign upd_idx = i_upd_pc[IDX_W+1:2];
    assign upd_tag = i_upd_pc[PC_W-1:IDX_W+2];

    assign unused_pc_lsb = ^{i_lkp_pc[1:0], i_upd_pc[1:0]};

    assign active = i_rst_n && (state_q == IDLE);

    always_comb begin
        for (int w = 0; w < 2; w++) begin
            lkp_match[w] = meta_q[w][lkp_idx].valid && (tag_q[w][lkp_idx] == lkp_tag);
            upd_match[w] = meta_q[w][upd_idx].valid && (tag_q[w][upd_idx] == upd_tag);
        end
    end

    // Way0 wins a double match; a flushing BTB never reports a hit.
    assign lkp_hit = (state_q == IDLE) && (|lkp_match);
    assign lkp_way = !lkp_match[0];

`ifdef BTB_COUNTER_EN
    assign lkp_taken = lkp_hit && meta_q[lkp_way][lkp_idx].cnt[1];
`else
    assign lkp_taken = lkp_hit;
`endif

    assign upd_hit = |upd_match;

    always_comb begin
        if (!meta_q[0][upd_idx].valid) begin
            alloc_way = 1'b0;
        end else if (!meta_q[1][upd_idx].valid) begin
            alloc_way = 1'b1;
        end else begin
            alloc_way = lru_q[upd_idx];
        end
    end

    assign upd_way = upd_hit ? !upd_match[0] : alloc_way;

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        ram_we     = '0;
        tag_we     = '0;
        meta_we    = '0;
        lru_we     = 1'b0;
        meta_wdata = '0;
        if (active && i_upd_valid) begin
            if (upd_hit) begin
                lru_we = 1'b1;
`ifdef BTB_COUNTER_EN
                ram_we[upd_way]  = 1'b1;
                meta_we[upd_way] = 1'b1;
                meta_wdata.valid = 1'b1;
                meta_wdata.cnt   = cnt_next(meta_q[upd_way][upd_idx].cnt, i_upd_taken);
`else
                // Without counters a not-taken resolution drops the entry (valid stays 0).
                if (i_upd_taken) begin
                    ram_we[upd_way] = 1'b1;
                end else begin
                    meta_we[upd_way] = 1'b1;
                end
`endif
            end else if (i_upd_taken) begin
                lru_we           = 1'b1;
                ram_we[upd_way]  = 1'b1;
                tag_we[upd_way]  = 1'b1;
                meta_we[upd_way] = 1'b1;
                meta_wdata.valid = 1'b1;
`ifdef BTB_COUNTER_EN
                meta_wdata.cnt   = CNT_INIT;
`endif
            end
        end
    end

    // A restart request clears set 0 on the same edge, so the pass resumes at set 1.
    assign flush_set = i_flush ? '0 : flush_cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_rst_n && (state_q == FLUSH)) begin
            meta_q[0][flush_set].valid <= 1'b0;
            meta_q[1][flush_set].valid <= 1'b0;
            lru_q[flush_set]           <= 1'b0;
        end else if (active) begin
            if (i_lkp_valid && lkp_hit) begin
                lru_q[lkp_idx] <= !lkp_way;
            end
            // Issued after the lookup write so an update to the same set takes precedence.
            if (lru_we) begin
                lru_q[upd_idx] <= !upd_way;
            end
            if (meta_we[0]) begin
                meta_q[0][upd_idx] <= meta_wdata;
            end
            if (meta_we[1]) begin
                meta_q[1][upd_idx] <= meta_wdata;
            end
            if (tag_we[0]) begin
                tag_q[0][upd_idx] <= upd_tag;
            end
            if (tag_we[1]) begin
                tag_q[1][upd_idx] <= upd_tag;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= FLUSH;
            flush_cnt_q <= '0;
            lkp_valid_q <= 1'b0;
            lkp_hit_q   <= 1'b0;
            lkp_taken_q <= 1'b0;
            lkp_way_q   <= 1'b0;
        end else begin
            lkp_valid_q <= i_lkp_valid;
            lkp_hit_q   <= lkp_hit;
            lkp_taken_q <= lkp_taken;
            lkp_way_q   <= lkp_way;
            case (state_q)
                IDLE: begin
                    if (i_flush) begin
                        state_q     <= FLUSH;
                        flush_cnt_q <= '0;
                    end
                end
                FLUSH: begin
                    if (i_flush) begin
                        flush_cnt_q <= IDX_W'(1);
                    end else if (flush_cnt_q == IDX_W'(NUM_SETS - 1)) begin
                        state_q     <= IDLE;
                        flush_cnt_q <= '0;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + IDX_W'(1);
                    end
                end
                default: begin
                    state_q     <= FLUSH;
                    flush_cnt_q <= '0;
                end
            endcase
        end
    end

    for (genvar w = 0; w < 2; w++) begin : g_way
        btb_way_ram #(
            .DEPTH  (NUM_SETS),
            .DATA_W (PC_W),
            .ADDR_W (IDX_W)
        ) u_way_ram (
            .i_clk (i_clk),
            .we    (ram_we[w]),
            .waddr (upd_idx),
            .wdata (i_upd_target),
            .raddr (lkp_idx),
            .rdata (ram_rdata[w])
        );
    end

    assign o_lkp_valid  = lkp_valid_q;
    assign o_lkp_hit    = lkp_hit_q;
    assign o_lkp_taken  = lkp_taken_q;
    assign o_lkp_target = lkp_hit_q ? ram_rdata[lkp_way_q] : '0;
    assign o_ready      = (state_q == IDLE);

endmodule

// File: tb/tb_btb_2way.sv
// tb_btb_2way: directed checks of btb_2way (NUM_SETS=256, PC_W=32) in either BTB_COUNTER_EN build.
module tb_btb_2way;

    localparam int NUM_SETS = 256;
    localparam int PC_W     = 32;

    logic            i_clk;
    logic            i_rst_n;
    logic            i_lkp_valid;
    logic [PC_W-1:0] i_lkp_pc;
    logic            o_lkp_valid;
    logic            o_lkp_hit;
    logic            o_lkp_taken;
    logic [PC_W-1:0] o_lkp_target;
    logic            i_upd_valid;
    logic [PC_W-1:0] i_upd_pc;
    logic [PC_W-1:0] i_upd_target;
    logic            i_upd_taken;
    logic            i_flush;
    logic            o_ready;

    int n_cmp;
    int n_err;
    int cyc;

    btb_2way #(
        .NUM_SETS (NUM_SETS),
        .PC_W     (PC_W)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_lkp_valid  (i_lkp_valid),
        .i_lkp_pc     (i_lkp_pc),
        .o_lkp_valid  (o_lkp_valid),
        .o_lkp_hit    (o_lkp_hit),
        .o_lkp_taken  (o_lkp_taken),
        .o_lkp_target (o_lkp_target),
        .i_upd_valid  (i_upd_valid),
        .i_upd_pc     (i_upd_pc),
        .i_upd_target (i_upd_target),
        .i_upd_taken  (i_upd_taken),
        .i_flush      (i_flush),
        .o_ready      (o_ready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish, required finish before 400000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
        i_upd_valid  = 1'b1;
        i_upd_pc     = pc;
        i_upd_target = tgt;
        i_upd_taken  = taken;
        tick();
        i_upd_valid  = 1'b0;
    endtask

    task automatic lkp(input string tag, input logic [31:0] pc,
                       input logic hit, input logic taken, input logic [31:0] tgt);
        i_lkp_valid = 1'b1;
        i_lkp_pc    = pc;
        tick();
        i_lkp_valid = 1'b0;
        check({tag, "_valid"}, o_lkp_valid, 1);
        check({tag, "_hit"}, o_lkp_hit, hit);
        check({tag, "_taken"}, o_lkp_taken, taken);
        check({tag, "_target"}, o_lkp_target, tgt);
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        i_rst_n      = 1'b0;
        i_lkp_valid  = 1'b0;
        i_lkp_pc     = '0;
        i_upd_valid  = 1'b0;
        i_upd_pc     = '0;
        i_upd_target = '0;
        i_upd_taken  = 1'b0;
        i_flush      = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_ready", o_ready, 0);
        check("rst_lkp_valid", o_lkp_valid, 0);
        check("rst_hit", o_lkp_hit, 0);
        check("rst_taken", o_lkp_taken, 0);
        check("rst_target", o_lkp_target, 0);

        // Release: ready after exactly 256 edges; lookups miss and an update is dropped meanwhile
        i_rst_n      = 1'b1;
        i_upd_valid  = 1'b1;
        i_upd_pc     = 32'h0000_1000;
        i_upd_target = 32'h0000_2000;
        i_upd_taken  = 1'b1;
        i_lkp_valid  = 1'b1;
        i_lkp_pc     = 32'h0000_1000;
        cyc = 0;
        do begin
            tick();
            cyc++;
            i_upd_valid = 1'b0;
            if (cyc == 1) check("rstwin_lkp_valid", o_lkp_valid, 1);
            check("rstwin_hit", o_lkp_hit, 0);
        end while (!o_ready && cyc < 1000);
        i_lkp_valid = 1'b0;
        check("rst_ready_delay", cyc, 256);
        tick();
        check("idle_lkp_valid_low", o_lkp_valid, 0);
        lkp("dropped_upd", 32'h0000_1000, 0, 0, 32'h0);

        // Allocate then hit on the next cycle
        upd(32'h0000_1000, 32'h0000_2000, 1);
        lkp("alloc", 32'h0000_1000, 1, 1, 32'h0000_2000);

`ifdef BTB_COUNTER_EN
        upd(32'h0000_1000, 32'h0000_2000, 0);
        lkp("cnt1", 32'h0000_1000, 1, 0, 32'h0000_2000);
        upd(32'h0000_1000, 32'h0000_2000, 0);
        lkp("cnt0", 32'h0000_1000, 1, 0, 32'h0000_2000);
        upd(32'h0000_1000, 32'h0000_2000, 0);
        upd(32'h0000_1000, 32'h0000_2000, 1);
        lkp("cnt_floor", 32'h0000_1000, 1, 0, 32'h0000_2000);
        upd(32'h0000_1000, 32'h0000_2000, 1);
        upd(32'h0000_1000, 32'h0000_2000, 1);
        upd(32'h0000_1000, 32'h0000_2000, 1);
        upd(32'h0000_1000, 32'h0000_3000, 0);
        lkp("cnt_cap", 32'h0000_1000, 1, 1, 32'h0000_3000);
`else
        upd(32'h0000_1000, 32'h0000_2000, 0);
        lkp("nt_inval", 32'h0000_1000, 0, 0, 32'h0);
        upd(32'h0000_1000, 32'h0000_2000, 0);
        lkp("nt_miss_nowrite", 32'h0000_1000, 0, 0, 32'h0);
        upd(32'h0000_1000, 32'h0000_3000, 1);
        lkp("realloc", 32'h0000_1000, 1, 1, 32'h0000_3000);
`endif
        upd(32'h0000_2004, 32'h0000_7000, 1);
        lkp("set1", 32'h0000_2004, 1, 1, 32'h0000_7000);

        // Flush re-asserted at cnt=100: ready low for 100+256 cycles
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        check("flush_ready_low", o_ready, 0);
        cyc = 0;
        repeat (100) begin
            tick();
            cyc++;
        end
        i_flush = 1'b1;
        tick();
        cyc++;
        i_flush = 1'b0;
        while (!o_ready && cyc < 2000) begin
            tick();
            cyc++;
        end
        check("flush_restart_delay", cyc, 356);
        lkp("flushed_a", 32'h0000_1000, 0, 0, 32'h0);
        lkp("flushed_b", 32'h0000_2004, 0, 0, 32'h0);

        // Three allocations into set 0: third evicts the LRU way (0x0)
        upd(32'h0000_0000, 32'h0000_00A0, 1);
        upd(32'h0000_0400, 32'h0000_00B0, 1);
        upd(32'h0000_0800, 32'h0000_00C0, 1);
        lkp("evict_0", 32'h0000_0000, 0, 0, 32'h0);
        lkp("keep_400", 32'h0000_0400, 1, 1, 32'h0000_00B0);
        lkp("keep_800", 32'h0000_0800, 1, 1, 32'h0000_00C0);

        // Lookup hit on way1 (0x400) points LRU at way0 (0x800)
        lkp("lru_touch", 32'h0000_0400, 1, 1, 32'h0000_00B0);
        upd(32'h0000_0000, 32'h0000_00D0, 1);
        lkp("lru_evict_800", 32'h0000_0800, 0, 0, 32'h0);
        lkp("lru_keep_400", 32'h0000_0400, 1, 1, 32'h0000_00B0);

        // Same-set lookup (way1) and update hit (way0): update's LRU choice wins
        i_lkp_valid  = 1'b1;
        i_lkp_pc     = 32'h0000_0400;
        i_upd_valid  = 1'b1;
        i_upd_pc     = 32'h0000_0000;
        i_upd_target = 32'h0000_00D4;
        i_upd_taken  = 1'b1;
        tick();
        i_lkp_valid = 1'b0;
        i_upd_valid = 1'b0;
        check("both_lkp_hit", o_lkp_hit, 1);
        check("both_lkp_target", o_lkp_target, 32'h0000_00B0);
        upd(32'h0000_0C00, 32'h0000_00E0, 1);
        lkp("upd_wins_evict", 32'h0000_0400, 0, 0, 32'h0);
        lkp("upd_wins_keep", 32'h0000_0000, 1, 1, 32'h0000_00D4);

        // Same-cycle update and lookup read the old contents
        i_lkp_valid  = 1'b1;
        i_lkp_pc     = 32'h0000_3008;
        i_upd_valid  = 1'b1;
        i_upd_pc     = 32'h0000_3008;
        i_upd_target = 32'h0000_5000;
        i_upd_taken  = 1'b1;
        tick();
        i_lkp_valid = 1'b0;
        i_upd_valid = 1'b0;
        check("rbw_new_hit", o_lkp_hit, 0);
        lkp("rbw_next", 32'h0000_3008, 1, 1, 32'h0000_5000);
        i_lkp_valid  = 1'b1;
        i_lkp_pc     = 32'h0000_3008;
        i_upd_valid  = 1'b1;
        i_upd_pc     = 32'h0000_3008;
        i_upd_target = 32'h0000_6000;
        i_upd_taken  = 1'b1;
        tick();
        i_lkp_valid = 1'b0;
        i_upd_valid = 1'b0;
        check("rbw_old_target", o_lkp_target, 32'h0000_5000);
        lkp("rbw_new_target", 32'h0000_3008, 1, 1, 32'h0000_6000);

        // Reset mid-flush restarts from set 0
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        repeat (10) tick();
        i_rst_n = 1'b0;
        tick();
        check("midrst_ready", o_ready, 0);
        check("midrst_lkp_valid", o_lkp_valid, 0);
        i_rst_n = 1'b1;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!o_ready && cyc < 1000);
        check("midrst_ready_delay", cyc, 256);
        lkp("midrst_miss", 32'h0000_3008, 0, 0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
